apb_spi_cmd_if: RTL and testbench
=================================

# apb_spi_cmd_if

APB3 slave front end for the SPI master controller. Software writes 32-bit command words (cmd[31:28], addr[27:24], len[23:16], wdata[15:0]) into a TX FIFO and reads received words from an RX FIFO. An issue FSM presents one command at a time on the controller's stream port, holds it until the controller accepts it, then waits for end-of-transmission before issuing the next. The block also owns the SPI clock-divider register and a sticky EOT interrupt.

## Interface
- TX_DEPTH, 4: TX command FIFO depth; power of two, ≥2.
- RX_DEPTH, 4: RX data FIFO depth; power of two, ≥2.
- DIV_RST, 8'd2: reset value of the clock divider.
- clk_i  in  1  system clock; also used as PCLK.
- rstn_i  in  1  asynchronous active-low reset.
- paddr_i  in  5  APB byte address; bits [4:2] decoded.
- psel_i, penable_i, pwrite_i  in  1 each  APB control.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data; combinational from registers and FIFO heads.
- pready_o  out  1  tied to 1.
- pslverr_o  out  1  error, valid in the access phase.
- spi_clk_div_o  out  8  divider value.
- spi_clk_div_vld_o  out  1  one-cycle pulse on each accepted divider write.
- stream_data_o  out  32  command word to the controller.
- stream_data_vld_o  out  1  command valid.
- stream_data_rdy_i  in  1  controller is in IDLE.
- rx_data_i  in  32  received word.
- rx_vld_i  in  1  received word valid.
- rx_rdy_o  out  1  = !rx_full.
- eot_i  in  1  end-of-transmission pulse from the controller.
- irq_o  out  1  interrupt, level.

## Operation
- An access occurs when psel_i & penable_i are high. All side effects happen in that cycle.
- Register map:
  - 0x00 CTRL, RW: [7:0] clk_div.
  - 0x04 TXDATA, WO: pushes a command word.
  - 0x08 RXDATA, RO: reads and pops the RX head.
  - 0x0C STATUS, RO: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] busy, [11:8] tx_count, [15:12] rx_count.
  - 0x10 IRQ: [0] eot_flag, write-1-to-clear; [1] eot_ie, RW.
- Unmapped addresses read 0 and return pslverr_o=1.
- CTRL write:
  - Accepted only when busy=0. Updates clk_div and pulses spi_clk_div_vld_o in the next cycle.
  - If busy=1: ignored, pslverr_o=1.
- TXDATA write:
  - Rejected with pslverr_o=1 if the FIFO is full, or if pwdata_i[31:28] is neither 4'b1011 (write) nor 4'b1010 (read).
  - Rejected words are dropped.
- RXDATA read:
  - If empty: prdata_o=0, pslverr_o=1, no pop.
  - Otherwise prdata_o = head, popped at the end of the cycle.
- busy = (issue state != I_IDLE) | !tx_empty.
- Issue FSM:
  - I_IDLE: if !tx_empty, go to I_PRESENT.
  - I_PRESENT: stream_data_vld_o=1 and stream_data_o = TX head, both stable. When stream_data_rdy_i is sampled 0 after having been 1 in this state (the controller left IDLE), pop the TX head and go to I_WAIT.
  - I_WAIT: vld=0. On eot_i, set eot_flag and go to I_IDLE.
- RX push occurs when rx_vld_i & rx_rdy_o. If the RX FIFO is full, the word is lost; the controller's rx_rdy is not guaranteed to back-pressure the SPI bit stream.

## Timing
- Reset values:
  - prdata_o = 0, pslverr_o = 0, pready_o = 1.
  - spi_clk_div_o = DIV_RST, spi_clk_div_vld_o = 0.
  - stream_data_vld_o = 0, stream_data_o = 0.
  - rx_rdy_o = 1, irq_o = 0.
  - Both FIFOs are empty and the FSM is in I_IDLE.
- Reset asserted mid-transfer returns everything to these values immediately; FIFO contents are discarded.
- Latency: a TXDATA write into an empty FIFO with the FSM in I_IDLE gives stream_data_vld_o=1 two cycles after the access cycle. vld stays high for at least 2 cycles, as the controller requires.
- FIFO counts are registered. Full and empty are evaluated at the start of the cycle. A simultaneous push and pop leaves the count unchanged; a push is still rejected if the FIFO is full at cycle start.
- Pointers wrap modulo the depth; counts are (log2 depth + 1) bits wide.
- eot_i and a W1C to eot_flag in the same cycle: set wins.
- eot_i arriving outside I_WAIT still sets eot_flag and causes no FSM change.

## Configuration
- SPI_IRQ_EN defined:
  - irq_o = eot_flag & eot_ie, registered, 1-cycle latency.
  - The IRQ register behaves as described above.
- SPI_IRQ_EN undefined:
  - irq_o = 0.
  - IRQ reads return 0 and writes are ignored without error.
  - eot_flag logic is removed.

## Test plan
- Reset, then read STATUS -> 0x0000_0005; read CTRL -> 0x02; irq_o=0.
- Write 0x10 to CTRL while idle -> spi_clk_div_o=0x10, one-cycle vld pulse. Repeat while busy -> pslverr_o=1 and the value is unchanged.
- Write TXDATA 0xB312_ABCD -> vld high with the word held until rdy drops. The FIFO pops, and vld stays 0 until eot_i. Then eot_flag=1 and irq_o=1 (with IRQ_EN, eot_ie=1).
- Write TXDATA 0x5000_0000 -> pslverr_o=1, tx_count stays 0. Push TX_DEPTH+1 valid words -> the last write errors and tx_full=1.
- Drive 5 RX words with RX_DEPTH=4 -> rx_rdy_o drops after 4 words. RXDATA reads return those 4 in order; a fifth read returns 0 with pslverr_o=1.
- Assert rstn_i in I_PRESENT -> vld=0 and FIFOs empty on the next edge; write 0x1 to IRQ -> eot_flag clears.

Source files
------------

// File: rtl/apb_spi_cmd_if.sv
// APB3 command/data front end for the SPI master: TX command FIFO, RX data FIFO,
// clock-divider register and issue FSM. Define SPI_IRQ_EN to build the sticky EOT interrupt.
module apb_spi_cmd_if #(
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4,
  parameter logic [7:0]  DIV_RST  = 8'd2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [4:0]  paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [7:0]  spi_clk_div_o,
  output logic        spi_clk_div_vld_o,
  output logic [31:0] stream_data_o,
  output logic        stream_data_vld_o,
  input  logic        stream_data_rdy_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_vld_i,
  output logic        rx_rdy_o,
  input  logic        eot_i,
  output logic        irq_o
);

  localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_TXDATA = 3'd1;
  localparam logic [2:0] SEL_RXDATA = 3'd2;
  localparam logic [2:0] SEL_STATUS = 3'd3;
  localparam logic [2:0] SEL_IRQ    = 3'd4;

  typedef enum logic [1:0] {
    I_IDLE    = 2'd0,
    I_PRESENT = 2'd1,
    I_WAIT    = 2'd2
  } issue_state_t;

  // APB access decode; every side effect is qualified by acc.
  logic       acc, wr_acc, rd_acc;
  logic [2:0] sel;
  logic       unused_paddr;

  assign acc          = psel_i & penable_i;
  assign wr_acc       = acc & pwrite_i;
  assign rd_acc       = acc & ~pwrite_i;
  assign sel          = paddr_i[4:2];
  assign unused_paddr = ^paddr_i[1:0];
  assign pready_o     = 1'b1;

  // TX command FIFO
  logic [31:0]      tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr, tx_rptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_empty, tx_full, tx_push, tx_pop, cmd_ok;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign cmd_ok   = (pwdata_i[31:28] == 4'b1011) | (pwdata_i[31:28] == 4'b1010);
  assign tx_push  = wr_acc & (sel == SEL_TXDATA) & ~tx_full & cmd_ok;

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wptr] <= pwdata_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX data FIFO; words arriving while full are dropped.
  logic [31:0]      rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_rdy_o = ~rx_full;
  assign rx_push  = rx_vld_i & ~rx_full;
  assign rx_pop   = rd_acc & (sel == SEL_RXDATA) & ~rx_empty;

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Issue FSM. Handshake: the word is offered with vld held high and stable; the
  // controller accepts by dropping rdy after having shown rdy=1 in this state.
  issue_state_t state, state_nxt;
  logic         seen_rdy, seen_rdy_nxt;
  logic         busy;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= I_IDLE;
      seen_rdy <= 1'b0;
    end else begin
      state    <= state_nxt;
      seen_rdy <= seen_rdy_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    seen_rdy_nxt      = seen_rdy;
    tx_pop            = 1'b0;
    stream_data_vld_o = 1'b0;
    case (state)
      I_IDLE: begin
        seen_rdy_nxt = 1'b0;
        if (!tx_empty) state_nxt = I_PRESENT;
      end
      I_PRESENT: begin
        stream_data_vld_o = 1'b1;
        if (stream_data_rdy_i) begin
          seen_rdy_nxt = 1'b1;
        end else if (seen_rdy) begin
          tx_pop       = 1'b1;
          seen_rdy_nxt = 1'b0;
          state_nxt    = I_WAIT;
        end
      end
      I_WAIT: begin
        if (eot_i) state_nxt = I_IDLE;
      end
      default: begin
        state_nxt    = I_IDLE;
        seen_rdy_nxt = 1'b0;
      end
    endcase
  end

  assign stream_data_o = stream_data_vld_o ? tx_mem[tx_rptr] : 32'h0;
  assign busy          = (state != I_IDLE) | ~tx_empty;

  // Clock divider; changing it mid-transfer would corrupt the SPI clock.
  logic ctrl_ok;
  assign ctrl_ok = wr_acc & (sel == SEL_CTRL) & ~busy;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      spi_clk_div_o     <= DIV_RST;
      spi_clk_div_vld_o <= 1'b0;
    end else begin
      spi_clk_div_vld_o <= ctrl_ok;
      if (ctrl_ok) spi_clk_div_o <= pwdata_i[7:0];
    end
  end

  // Sticky EOT interrupt
  logic [31:0] irq_rdata;
`ifdef SPI_IRQ_EN
  logic eot_flag, eot_ie, irq_q, irq_wr;
  assign irq_wr = wr_acc & (sel == SEL_IRQ);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      eot_flag <= 1'b0;
      eot_ie   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (eot_i)                     eot_flag <= 1'b1;
      else if (irq_wr & pwdata_i[0]) eot_flag <= 1'b0;
      if (irq_wr) eot_ie <= pwdata_i[1];
      irq_q <= eot_flag & eot_ie;
    end
  end

  assign irq_o     = irq_q;
  assign irq_rdata = {30'h0, eot_ie, eot_flag};
`else
  assign irq_o     = 1'b0;
  assign irq_rdata = 32'h0;
`endif

  // Read data and error response, driven only during the access phase.
  logic [31:0] status_word;
  assign status_word = {16'h0, 4'(rx_count), 4'(tx_count), 3'b000,
                        busy, rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    prdata_o  = 32'h0;
    pslverr_o = 1'b0;
    if (acc) begin
      case (sel)
        SEL_CTRL: begin
          if (pwrite_i) pslverr_o = busy;
          else          prdata_o  = {24'h0, spi_clk_div_o};
        end
        SEL_TXDATA: begin
          if (pwrite_i) pslverr_o = tx_full | ~cmd_ok;
        end
        SEL_RXDATA: begin
          if (!pwrite_i) begin
            pslverr_o = rx_empty;
            if (!rx_empty) prdata_o = rx_mem[rx_rptr];
          end
        end
        SEL_STATUS: begin
          if (!pwrite_i) prdata_o = status_word;
        end
        SEL_IRQ: begin
          if (!pwrite_i) prdata_o = irq_rdata;
        end
        default: pslverr_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_cmd_if.sv
// Scoreboard bench for apb_spi_cmd_if: queue-based reference model of both FIFOs,
// the divider and the EOT flag; monitors check APB responses and issued commands.
module tb_apb_spi_cmd_if;

  localparam int         TX_DEPTH = 4;
  localparam int         RX_DEPTH = 4;
  localparam logic [7:0] DIV_RST  = 8'd2;
  localparam logic [4:0] A_CTRL = 5'h00, A_TX = 5'h04, A_RX = 5'h08, A_ST = 5'h0C, A_IRQ = 5'h10;

  logic        clk, rstn;
  logic [4:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  div;
  logic        div_vld;
  logic [31:0] stream_data;
  logic        stream_vld, stream_rdy;
  logic [31:0] rx_data;
  logic        rx_vld, rx_rdy, eot, irq;

  apb_spi_cmd_if #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .DIV_RST(DIV_RST)) dut (
    .clk_i(clk), .rstn_i(rstn), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .spi_clk_div_o(div), .spi_clk_div_vld_o(div_vld),
    .stream_data_o(stream_data), .stream_data_vld_o(stream_vld),
    .stream_data_rdy_i(stream_rdy), .rx_data_i(rx_data), .rx_vld_i(rx_vld),
    .rx_rdy_o(rx_rdy), .eot_i(eot), .irq_o(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];   // {pslverr, prdata} per APB access
  logic [31:0] cmd_q[$];   // words expected on the stream port, in order

  // reference model
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  bit          m_inflight;
  bit          m_flag, m_ie;
  logic [7:0]  m_div;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_exp();
    int t = m_tx.size();
    int r = m_rx.size();
    logic [31:0] s = 32'h0;
    s[0]     = (t == 0);
    s[1]     = (t == TX_DEPTH);
    s[2]     = (r == 0);
    s[3]     = (r == RX_DEPTH);
    s[4]     = (t != 0) || m_inflight;
    s[11:8]  = t[3:0];
    s[15:12] = r[3:0];
    return s;
  endfunction

  function automatic logic [31:0] irq_reg_exp();
`ifdef SPI_IRQ_EN
    return {30'h0, m_ie, m_flag};
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic irq_line_exp();
`ifdef SPI_IRQ_EN
    return m_flag & m_ie;
`else
    return 1'b0;
`endif
  endfunction

  // driver tasks
  task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_status();
    apb(1'b0, A_ST, 32'h0, status_exp(), 1'b0);
  endtask

  task automatic read_rx();
    logic [31:0] d;
    if (m_rx.size() == 0) apb(1'b0, A_RX, 32'h0, 32'h0, 1'b1);
    else begin
      d = m_rx.pop_front();
      apb(1'b0, A_RX, 32'h0, d, 1'b0);
    end
  endtask

  task automatic tx_write(input logic [31:0] w, output bit ok);
    ok = (w[31:28] == 4'hB || w[31:28] == 4'hA) && (m_tx.size() < TX_DEPTH);
    if (ok) begin
      m_tx.push_back(w);
      cmd_q.push_back(w);
    end
    apb(1'b1, A_TX, w, 32'h0, !ok);
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    bit ok;
    ok = (m_tx.size() == 0) && !m_inflight;
    apb(1'b1, A_CTRL, v, 32'h0, !ok);
    if (ok) m_div = v[7:0];
    chk("div_vld_pulse", {31'h0, div_vld}, {31'h0, ok});
    chk("div_value", {24'h0, div}, {24'h0, m_div});
    @(posedge clk); #1;
    chk("div_vld_low", {31'h0, div_vld}, 32'h0);
  endtask

  task automatic irq_write(input logic [31:0] v);
    apb(1'b1, A_IRQ, v, 32'h0, 1'b0);
    m_ie = v[1];
    if (v[0]) m_flag = 1'b0;
  endtask

  task automatic drive_rx(input logic [31:0] d);
    rx_data = d;
    rx_vld  = 1'b1;
    chk("rx_rdy", {31'h0, rx_rdy}, {31'h0, (m_rx.size() < RX_DEPTH)});
    if (m_rx.size() < RX_DEPTH) m_rx.push_back(d);
    @(posedge clk); #1;
    rx_vld = 1'b0;
  endtask

  task automatic pulse_eot();
    eot = 1'b1;
    @(posedge clk); #1;
    eot = 1'b0;
    m_flag = 1'b1;
  endtask

  // Behaves as the SPI controller for one command: accept, receive words, signal EOT.
  task automatic serve(input int hold, input int nrx);
    int n = 0;
    while (!stream_vld && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("vld_wait", {31'h0, stream_vld}, 32'h1);
    repeat (hold) @(posedge clk);
    #1 stream_rdy = 1'b0;
    @(posedge clk); #1;
    if (m_tx.size() != 0) void'(m_tx.pop_front());
    m_inflight = 1'b1;
    chk("vld_after_accept", {31'h0, stream_vld}, 32'h0);
    for (int k = 0; k < nrx; k++) drive_rx($urandom);
    chk("vld_in_wait", {31'h0, stream_vld}, 32'h0);
    pulse_eot();
    stream_rdy = 1'b1;
    m_inflight = 1'b0;
    @(posedge clk); #1;
    chk("irq_line", {31'h0, irq}, {31'h0, irq_line_exp()});
  endtask

  // scoreboard monitors
  logic [32:0] apb_e;
  always @(negedge clk) begin
    if (rstn && psel && penable) begin
      if (exp_q.size() == 0) chk("apb_unexpected", 32'h1, 32'h0);
      else begin
        apb_e = exp_q.pop_front();
        chk("prdata", prdata, apb_e[31:0]);
        chk("pslverr", {31'h0, pslverr}, {31'h0, apb_e[32]});
      end
    end
  end

  logic [31:0] held_cmd = 32'h0;
  logic        prev_vld = 1'b0;
  always @(negedge clk) begin
    if (stream_vld) begin
      if (!prev_vld) begin
        if (cmd_q.size() == 0) chk("stream_unexpected", 32'h1, 32'h0);
        else held_cmd = cmd_q.pop_front();
      end
      chk("stream_data", stream_data, held_cmd);
    end
    prev_vld = stream_vld;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    bit ok;
    logic [31:0] w;
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    stream_rdy = 1'b1; rx_data = '0; rx_vld = 1'b0; eot = 1'b0;
    m_inflight = 0; m_flag = 0; m_ie = 0; m_div = DIV_RST;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h1);
    chk("rst_div", {24'h0, div}, {24'h0, DIV_RST});
    chk("rst_div_vld", {31'h0, div_vld}, 32'h0);
    chk("rst_stream_vld", {31'h0, stream_vld}, 32'h0);
    chk("rst_stream_data", stream_data, 32'h0);
    chk("rst_rx_rdy", {31'h0, rx_rdy}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rstn = 1'b1;

    apb(1'b0, A_ST, 32'h0, 32'h0000_0005, 1'b0);
    apb(1'b0, A_CTRL, 32'h0, {24'h0, DIV_RST}, 1'b0);
    apb(1'b0, 5'h14, 32'h0, 32'h0, 1'b1);
    apb(1'b0, 5'h1C, 32'h0, 32'h0, 1'b1);
    ctrl_write(32'h10);
    irq_write(32'h2);
    apb(1'b0, A_IRQ, 32'h0, irq_reg_exp(), 1'b0);

    // first command: latency and accept/EOT flow
    tx_write(32'hB312_ABCD, ok);
    chk("latency_c1", {31'h0, stream_vld}, 32'h0);
    @(posedge clk); #1;
    chk("latency_c2", {31'h0, stream_vld}, 32'h1);
    ctrl_write(32'h33);
    read_status();
    serve(2, 1);
    apb(1'b0, A_IRQ, 32'h0, irq_reg_exp(), 1'b0);
    irq_write(32'h3);
    apb(1'b0, A_IRQ, 32'h0, irq_reg_exp(), 1'b0);
    read_rx();

    // illegal command and FIFO full
    tx_write(32'h5000_0000, ok);
    read_status();
    for (int i = 0; i <= TX_DEPTH; i++) tx_write({4'hA, 28'($urandom)}, ok);
    read_status();
    ctrl_write(32'h77);
    for (int i = 0; i < TX_DEPTH; i++) serve($urandom_range(1, 3), 0);
    read_status();

    // RX overflow and drain
    for (int i = 0; i < RX_DEPTH + 1; i++) drive_rx($urandom);
    read_status();
    for (int i = 0; i < RX_DEPTH + 1; i++) read_rx();

    // randomized traffic
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0:       w[31:28] = 4'($urandom_range(0, 9));
        1:       w[31:28] = 4'hA;
        default: w[31:28] = 4'hB;
      endcase
      tx_write(w, ok);
      if (ok) begin
        if ($urandom_range(0, 1) == 1) ctrl_write($urandom);
        serve($urandom_range(1, 3), $urandom_range(0, 3));
      end
      read_status();
      repeat ($urandom_range(0, 2)) read_rx();
    end
    while (m_rx.size() != 0) read_rx();

    // EOT and W1C in the same cycle: set wins
    irq_write(32'h2);
    fork
      irq_write(32'h3);
      begin
        @(posedge clk); @(posedge clk); #1 eot = 1'b1;
        @(posedge clk); #1 eot = 1'b0;
      end
    join
    m_flag = 1'b1;
    apb(1'b0, A_IRQ, 32'h0, irq_reg_exp(), 1'b0);

    // reset while a command is presented
    drive_rx(32'hDEAD_BEEF);
    tx_write(32'hB000_1234, ok);
    @(posedge clk); #1;
    chk("pre_reset_vld", {31'h0, stream_vld}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("reset_vld", {31'h0, stream_vld}, 32'h0);
    chk("reset_stream_data", stream_data, 32'h0);
    chk("reset_div", {24'h0, div}, {24'h0, DIV_RST});
    chk("reset_irq", {31'h0, irq}, 32'h0);
    m_tx.delete(); m_rx.delete(); cmd_q.delete();
    m_inflight = 0; m_flag = 0; m_ie = 0; m_div = DIV_RST;
    @(posedge clk); #1;
    rstn = 1'b1;
    read_status();
    apb(1'b0, A_CTRL, 32'h0, {24'h0, DIV_RST}, 1'b0);

    // EOT outside a transfer sets the flag only; then W1C clears it
    pulse_eot();
    apb(1'b0, A_IRQ, 32'h0, irq_reg_exp(), 1'b0);
    read_status();
    irq_write(32'h1);
    apb(1'b0, A_IRQ, 32'h0, irq_reg_exp(), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("apb_queue_drained", exp_q.size(), 32'h0);
    chk("cmd_queue_drained", cmd_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
